// File: rtl/wb_select_buffer_if.sv
// Write-back select request/response bundle: producer-side request fields and
// consumer-side buffered result, with master (producer/consumer) and slave (buffer) views.
interface wb_select_buffer_if #(
    parameter int WIDTH = 64,
    parameter int NSRC  = 5,
    parameter int SELW  = $clog2(NSRC + 1)
);
    logic                  in_valid;
    logic                  in_ready;
    logic [SELW-1:0]       sel;
    logic [NSRC*WIDTH-1:0] src;
    logic                  flag_in;
    logic [2:0]            ext_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_err;

    modport master (
        output in_valid, sel, src, flag_in, ext_mode, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, sel, src, flag_in, ext_mode, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/wb_select_buffer.sv
// Registered write-back source selector: picks a source or the compare flag, applies
// load-style extension, and queues the result in a 2-entry valid/ready buffer.
module wb_select_buffer #(
    parameter int WIDTH = 64,
    parameter int NSRC  = 5,
    parameter int SELW  = $clog2(NSRC + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    wb_select_buffer_if.slave   bus
);
    typedef struct packed {
        logic             err;
        logic [WIDTH-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    logic [WIDTH-1:0] sel_val;
    logic             sel_err;
    logic [WIDTH-1:0] ext_val;
    logic [WIDTH-1:0] sx32;
    logic [WIDTH-1:0] zx32;
    entry_t           entry_d;

    state_t state_q;
    entry_t head_q;
    entry_t tail_q;
    logic   in_ready_q;
    logic   out_valid_q;
    logic   accept;
    logic   release_w;

    always_comb begin
        sel_val = '0;
        sel_err = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (bus.sel == SELW'(k)) sel_val = bus.src[k*WIDTH +: WIDTH];
        end
        if (bus.sel == SELW'(NSRC)) sel_val = {{(WIDTH-1){1'b0}}, bus.flag_in};
        else if (int'(bus.sel) > NSRC) sel_err = 1'b1;
    end

    // A 32-bit datapath has nothing to extend a word into, so the word modes pass through.
    if (WIDTH > 32) begin : g_ext32
        assign sx32 = {{(WIDTH-32){sel_val[31]}}, sel_val[31:0]};
        assign zx32 = {{(WIDTH-32){1'b0}}, sel_val[31:0]};
    end else begin : g_pass32
        assign sx32 = sel_val;
        assign zx32 = sel_val;
    end

    always_comb begin
        ext_val = sel_val;
        case (bus.ext_mode)
            3'b001:  ext_val = {{(WIDTH-8){sel_val[7]}}, sel_val[7:0]};
            3'b010:  ext_val = {{(WIDTH-16){sel_val[15]}}, sel_val[15:0]};
            3'b011:  ext_val = sx32;
            3'b100:  ext_val = {{(WIDTH-8){1'b0}}, sel_val[7:0]};
            3'b101:  ext_val = {{(WIDTH-16){1'b0}}, sel_val[15:0]};
            3'b110:  ext_val = zx32;
            default: ext_val = sel_val;
        endcase
        if (sel_err) ext_val = '0;
        entry_d = '{err: sel_err, data: ext_val};
    end

    assign accept    = bus.in_valid && in_ready_q;
    assign release_w = out_valid_q && bus.out_ready;

    // Ready/valid are registered alongside the occupancy so neither depends on out_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            tail_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_q      <= entry_d;
                        state_q     <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && release_w) begin
                        head_q <= entry_d;
                    end else if (accept) begin
                        tail_q     <= entry_d;
                        state_q    <= FULL;
                        in_ready_q <= 1'b0;
                    end else if (release_w) begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (release_w) begin
                        head_q     <= tail_q;
                        state_q    <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = head_q.data;
    assign bus.out_err   = head_q.err;
endmodule

// File: tb/tb_wb_select_buffer.sv
// Bench for wb_select_buffer: directed steps plus random traffic against a queue-based
// reference of the selector/extension rules and 2-deep FIFO occupancy.
module tb_wb_select_buffer;
    logic clk = 1'b0;
    logic reset_n;
    int   npass = 0;
    int   ntot  = 0;
    int   nfail = 0;

    typedef struct {
        logic [63:0] d;
        logic        e;
    } ent_t;

    ent_t        q[$];
    logic [63:0] slot[5];
    logic        acc;

    wb_select_buffer_if #(.WIDTH(64), .NSRC(5)) bus ();

    wb_select_buffer #(.WIDTH(64), .NSRC(5)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic ent_t ref_ent(int s, logic [2:0] m, logic f);
        logic [63:0] v;
        ent_t        r;
        r.e = (s > 5);
        if (s < 5)       v = slot[s];
        else if (s == 5) v = {63'd0, f};
        else             v = 64'd0;
        case (m)
            3'd1:    v = (v & 64'hFF)        - (v[7]  ? 64'h100         : 64'h0);
            3'd2:    v = (v & 64'hFFFF)      - (v[15] ? 64'h1_0000      : 64'h0);
            3'd3:    v = (v & 64'hFFFF_FFFF) - (v[31] ? 64'h1_0000_0000 : 64'h0);
            3'd4:    v = v & 64'hFF;
            3'd5:    v = v & 64'hFFFF;
            3'd6:    v = v & 64'hFFFF_FFFF;
            default: v = v;
        endcase
        r.d = v;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            chk("out_data", bus.out_data, q[0].d);
            chk("out_err", 64'(bus.out_err), 64'(q[0].e));
        end
    endtask

    task automatic cyc(input logic v, input int s, input logic [2:0] m, input logic f,
                       input logic ordy, output logic a);
        logic rel;
        ent_t e;
        @(negedge clk);
        bus.in_valid  = v;
        bus.sel       = 3'(s);
        bus.ext_mode  = m;
        bus.flag_in   = f;
        bus.out_ready = ordy;
        for (int k = 0; k < 5; k++) bus.src[k*64 +: 64] = slot[k];
        check_state();
        a   = v && (q.size() < 2);
        rel = (q.size() > 0) && ordy;
        e   = ref_ent(s, m, f);
        @(posedge clk);
        if (rel) void'(q.pop_front());
        if (a) q.push_back(e);
    endtask

    task automatic peek(input string tag, input logic [63:0] d, input logic e);
        #1;
        chk({tag, "_data"}, bus.out_data, d);
        chk({tag, "_err"}, 64'(bus.out_err), 64'(e));
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [2:0]  xm[4];
        logic [63:0] xe[4];
        logic [63:0] a_val;
        int          tries;

        xm = '{3'b001, 3'b101, 3'b011, 3'b110};
        xe = '{64'hFFFF_FFFF_FFFF_FFF0, 64'h0000_0000_0000_F0F0,
               64'hFFFF_FFFF_8000_F0F0, 64'h0000_0000_8000_F0F0};

        // Reset held low with random inputs
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sel       = '0;
        bus.src       = '0;
        bus.flag_in   = 1'b0;
        bus.ext_mode  = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid  = 1'($urandom);
            bus.sel       = 3'($urandom);
            bus.src       = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
            bus.flag_in   = 1'($urandom);
            bus.ext_mode  = 3'($urandom);
            bus.out_ready = 1'($urandom);
            #1;
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
            chk("rst_out_data", bus.out_data, 64'd0);
            chk("rst_out_err", 64'(bus.out_err), 64'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        // Source sweep
        for (int k = 0; k < 5; k++) slot[k] = 64'h1111_1111_1111_1111 * 64'(k + 1);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, k, 3'b000, 1'b0, 1'b1, acc);
            peek("sweep", 64'h1111_1111_1111_1111 * 64'(k + 1), 1'b0);
        end
        cyc(1'b0, 0, 3'b000, 1'b0, 1'b1, acc);

        // Flag and illegal selects
        cyc(1'b1, 5, 3'b000, 1'b1, 1'b1, acc);
        peek("flag", 64'h1, 1'b0);
        cyc(1'b1, 6, 3'b000, 1'b0, 1'b1, acc);
        peek("sel6", 64'h0, 1'b1);
        cyc(1'b1, 7, 3'b001, 1'b1, 1'b1, acc);
        peek("sel7", 64'h0, 1'b1);
        cyc(1'b0, 0, 3'b000, 1'b0, 1'b1, acc);

        // Extension modes on a fixed word
        slot[2] = 64'h0000_0000_8000_F0F0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 2, xm[i], 1'b0, 1'b1, acc);
            peek("ext", xe[i], 1'b0);
        end
        cyc(1'b0, 0, 3'b000, 1'b0, 1'b1, acc);

        // Back-pressure: A, B accepted, C held until space opens
        slot[0] = rnd64();
        slot[1] = rnd64();
        slot[3] = rnd64();
        a_val   = slot[0];
        cyc(1'b1, 0, 3'b000, 1'b0, 1'b0, acc);
        cyc(1'b1, 1, 3'b000, 1'b0, 1'b0, acc);
        cyc(1'b1, 3, 3'b000, 1'b0, 1'b0, acc);
        cyc(1'b1, 3, 3'b000, 1'b0, 1'b0, acc);
        peek("bp_holdA", a_val, 1'b0);
        chk("bp_full_ready", 64'(bus.in_ready), 64'd0);
        tries = 0;
        do begin
            cyc(1'b1, 3, 3'b000, 1'b0, 1'b1, acc);
            tries++;
        end while (!acc && tries < 6);
        chk("bp_c_accept_bound", 64'(tries <= 2), 64'd1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 3'b000, 1'b0, 1'b1, acc);

        // Simultaneous accept and release in ONE
        slot[4] = rnd64();
        cyc(1'b1, 4, 3'b000, 1'b0, 1'b1, acc);
        for (int i = 0; i < 4; i++) begin
            slot[4] = rnd64();
            cyc(1'b1, 4, 3'b000, 1'b0, 1'b1, acc);
            peek("sim_d", slot[4], 1'b0);
            chk("sim_in_ready", 64'(bus.in_ready), 64'd1);
        end
        for (int i = 0; i < 2; i++) cyc(1'b0, 0, 3'b000, 1'b0, 1'b1, acc);

        // Asynchronous reset while FULL
        cyc(1'b1, 0, 3'b000, 1'b0, 1'b0, acc);
        cyc(1'b1, 1, 3'b000, 1'b0, 1'b0, acc);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("arst_out_data", bus.out_data, 64'd0);
        chk("arst_out_err", 64'(bus.out_err), 64'd0);
        q.delete();
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset_n      = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 5; k++) slot[k] = rnd64();
            cyc(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                3'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), acc);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, 3'b000, 1'b0, 1'b1, acc);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
